// File: rtl/exu_div.sv
// rtl/exu_div.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module exu_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            rem,
  input  logic            unsign,
  input  logic [4:0]      rd_addr,
  input  logic [31:0]     instr_tag,
  input  logic            flush,
  output logic            busy,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd_addr,
  output logic [31:0]     wb_instr_tag
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;      // dividend, becomes the quotient bit by bit
  logic [XLEN-1:0]  dvs_q, dvs_d;      // divisor magnitude
  logic [XLEN-1:0]  prem_q, prem_d;    // partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rem_op_q, rem_op_d;
  logic             uns_q, uns_d;
  logic             q_sgn_q, q_sgn_d;  // operand signs differ
  logic             r_sgn_q, r_sgn_d;  // dividend sign
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      tag_q, tag_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_tag_q, wb_tag_d;

  logic [XLEN:0]    shifted, diff;
  logic [XLEN-1:0]  q_fix, r_fix, result;
  logic             s1_neg, s2_neg;

  assign s1_neg  = ~unsign & rs1_data[XLEN-1];
  assign s2_neg  = ~unsign & rs2_data[XLEN-1];
  assign shifted = {prem_q, dvd_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign q_fix   = (~uns_q & q_sgn_q) ? (~dvd_q + XLEN'(1)) : dvd_q;
  assign r_fix   = (~uns_q & r_sgn_q) ? (~prem_q + XLEN'(1)) : prem_q;
  assign result  = rem_op_q ? r_fix : q_fix;

  // Next-state logic: operand capture, one restoring step per CALC cycle, result capture
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    rem_op_d  = rem_op_q;
    uns_d     = uns_q;
    q_sgn_d   = q_sgn_q;
    r_sgn_d   = r_sgn_q;
    rd_d      = rd_q;
    tag_d     = tag_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_tag_d  = wb_tag_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          rem_op_d = rem;
          uns_d    = unsign;
          rd_d     = rd_addr;
          tag_d    = instr_tag;
          state_d  = DONE;
          q_sgn_d  = 1'b0;
          r_sgn_d  = 1'b0;
          if (rs2_data == '0) begin
            // Preload so DONE yields quotient all-ones and remainder = dividend
            dvd_d  = '1;
            prem_d = rs1_data;
          end else if (!unsign && rs1_data == INT_MIN && rs2_data == '1) begin
            dvd_d  = INT_MIN;
            prem_d = '0;
          end else begin
            dvd_d   = s1_neg ? (~rs1_data + XLEN'(1)) : rs1_data;
            dvs_d   = s2_neg ? (~rs2_data + XLEN'(1)) : rs2_data;
            prem_d  = '0;
            cnt_d   = CNT_W'(XLEN);
            q_sgn_d = rs1_data[XLEN-1] ^ rs2_data[XLEN-1];
            r_sgn_d = rs1_data[XLEN-1];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!diff[XLEN]) begin
          prem_d = diff[XLEN-1:0];
          dvd_d  = {dvd_q[XLEN-2:0], 1'b1};
        end else begin
          prem_d = shifted[XLEN-1:0];
          dvd_d  = {dvd_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          wb_data_d = result;
          wb_rd_d   = rd_q;
          wb_tag_d  = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      rem_op_q  <= 1'b0;
      uns_q     <= 1'b0;
      q_sgn_q   <= 1'b0;
      r_sgn_q   <= 1'b0;
      rd_q      <= '0;
      tag_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_tag_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      rem_op_q  <= rem_op_d;
      uns_q     <= uns_d;
      q_sgn_q   <= q_sgn_d;
      r_sgn_q   <= r_sgn_d;
      rd_q      <= rd_d;
      tag_q     <= tag_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_tag_q  <= wb_tag_d;
    end
  end

  // Write-back beat is live in DONE; otherwise the last beat's fields are held
  assign busy         = busy_q;
  assign wb_valid     = (state_q == DONE) & ~flush;
  assign wb_data      = (state_q == DONE) ? result : wb_data_q;
  assign wb_rd_addr   = (state_q == DONE) ? rd_q   : wb_rd_q;
  assign wb_instr_tag = (state_q == DONE) ? tag_q  : wb_tag_q;

endmodule

// File: tb/tb_exu_div.sv
// tb/tb_exu_div.sv - self-checking bench for exu_div
module tb_exu_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rem, unsign, flush;
  logic [31:0] rs1_data, rs2_data, instr_tag;
  logic [4:0]  rd_addr;
  logic        busy, wb_valid;
  logic [31:0] wb_data, wb_instr_tag;
  logic [4:0]  wb_rd_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exu_div dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rem(rem), .unsign(unsign), .rd_addr(rd_addr), .instr_tag(instr_tag), .flush(flush),
    .busy(busy), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_instr_tag(wb_instr_tag)
  );

  // Architectural RISC-V M result, from plain arithmetic
  function automatic logic [31:0] ref_result(logic [31:0] a, logic [31:0] b, logic r, logic u);
    longint sa, sb;
    if (b == 0) return r ? a : 32'hFFFF_FFFF;
    if (u) return r ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'h0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    return r ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int ref_latency(logic [31:0] a, logic [31:0] b, logic u);
    if (b == 0) return 1;
    if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one op at the current negedge and checks busy/wb_valid every cycle
  task automatic run_and_check(input string nm, input logic [31:0] a, input logic [31:0] b,
                               input logic r, input logic u, input logic [4:0] rd,
                               input logic [31:0] tag, input logic [31:0] exp, input int lat);
    rs1_data = a; rs2_data = b; rem = r; unsign = u; rd_addr = rd; instr_tag = tag; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; rem = ~r; unsign = ~u;
    rd_addr = 5'($urandom); instr_tag = $urandom;
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      if (cyc > 1) @(negedge clk);
      n_cmp++;
      if (busy !== (cyc <= lat)) begin
        n_err++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", nm, cyc, busy, (cyc <= lat));
      end
      n_cmp++;
      if (wb_valid !== (cyc == lat)) begin
        n_err++;
        $display("FAIL %s wb_valid cyc=%0d got=%b want=%b", nm, cyc, wb_valid, (cyc == lat));
      end
      if (cyc >= lat) begin
        n_cmp++;
        if (wb_data !== exp || wb_rd_addr !== rd || wb_instr_tag !== tag) begin
          n_err++;
          $display("FAIL %s wb cyc=%0d got=%h/%0d/%h want=%h/%0d/%h", nm, cyc,
                   wb_data, wb_rd_addr, wb_instr_tag, exp, rd, tag);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; flush = 0; rem = 0; unsign = 0;
    rs1_data = 0; rs2_data = 0; rd_addr = 0; instr_tag = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, wb_valid} !== 2'b00 || wb_data !== 0 || wb_rd_addr !== 0 || wb_instr_tag !== 0) begin
      n_err++;
      $display("FAIL reset outputs got=%b%b %h %0d %h want=00 0 0 0",
               busy, wb_valid, wb_data, wb_rd_addr, wb_instr_tag);
    end
  endtask

  task automatic test_directed();
    run_and_check("divu_100_7", 100, 7, 0, 1, 5'd3, 32'hA5A5_0001, 14, 33);
    run_and_check("rem_m100_7", 32'hFFFF_FF9C, 7, 1, 0, 5'd4, 32'h0000_0002, 32'hFFFF_FFFE, 33);
    run_and_check("div_m100_7", 32'hFFFF_FF9C, 7, 0, 0, 5'd5, 32'h0000_0003, 32'hFFFF_FFF2, 33);
    run_and_check("divu_by0", 5, 0, 0, 1, 5'd6, 32'h0000_0004, 32'hFFFF_FFFF, 1);
    run_and_check("remu_by0", 5, 0, 1, 1, 5'd7, 32'h0000_0005, 5, 1);
    run_and_check("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'd8, 32'h6, 32'h8000_0000, 1);
    run_and_check("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 5'd9, 32'h7, 0, 1);
    run_and_check("divu_max", 32'hFFFF_FFFF, 1, 0, 1, 5'd0, 32'h8, 32'hFFFF_FFFF, 33);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic r, u;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; u = 1'($urandom); r = 1'($urandom);
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -$urandom_range(1, 300);
        default: b = $urandom;
      endcase
      run_and_check("random", a, b, r, u, 5'($urandom), $urandom, ref_result(a, b, r, u),
                    ref_latency(a, b, u));
    end
  endtask

  task automatic test_flush();
    bit seen = 0;
    rs1_data = 100; rs2_data = 7; rem = 0; unsign = 1; rd_addr = 1; instr_tag = 32'hF1; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (wb_valid) seen = 1;
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    n_cmp++;
    if (busy !== 1'b0 || seen || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_mid busy=%b beat_seen=%0d want busy=0 no beat", busy, seen);
    end
    run_and_check("after_flush", 20, 3, 0, 1, 5'd11, 32'hF2, 6, 33);
  endtask

  task automatic test_flush_done();
    rs1_data = 50; rs2_data = 5; rem = 0; unsign = 1; rd_addr = 2; instr_tag = 32'hD0; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (32) @(negedge clk);
    flush = 1;
    #1;
    n_cmp++;
    if (wb_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL flush_done wb_valid=%b busy=%b want 0/1", wb_valid, busy);
    end
    @(negedge clk);
    flush = 0;
    n_cmp++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_done_after busy=%b wb_valid=%b want 0/0", busy, wb_valid);
    end
    start = 1; flush = 1; rs2_data = 3;
    @(negedge clk);
    start = 0; flush = 0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_with_flush busy=%b want 0", busy);
    end
  endtask

  task automatic test_start_while_busy();
    int beats = 0;
    rs1_data = 1000; rs2_data = 10; rem = 0; unsign = 1; rd_addr = 12; instr_tag = 32'hB1; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 5) begin
        start = 1; rs1_data = 77; rs2_data = 0; rem = 1; rd_addr = 13; instr_tag = 32'hB2;
      end
      if (cyc == 6) start = 0;
      if (wb_valid) begin
        beats++;
        n_cmp++;
        if (cyc != 33 || wb_data !== 100 || wb_rd_addr !== 12 || wb_instr_tag !== 32'hB1) begin
          n_err++;
          $display("FAIL busy_start beat cyc=%0d got=%h/%0d/%h want cyc33 64/12/b1",
                   cyc, wb_data, wb_rd_addr, wb_instr_tag);
        end
      end
    end
    n_cmp++;
    if (beats != 1) begin
      n_err++;
      $display("FAIL busy_start beats got=%0d want=1", beats);
    end
  endtask

  task automatic test_async_reset();
    int beats = 0;
    rs1_data = 999; rs2_data = 4; rem = 0; unsign = 1; rd_addr = 14; instr_tag = 32'hC1; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
    #1 rst_n = 0;
    #1;
    n_cmp++;
    if ({busy, wb_valid} !== 2'b00 || wb_data !== 0 || wb_rd_addr !== 0 || wb_instr_tag !== 0) begin
      n_err++;
      $display("FAIL async_reset got=%b%b %h %0d %h want=00 0 0 0",
               busy, wb_valid, wb_data, wb_rd_addr, wb_instr_tag);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (40) begin
      @(negedge clk);
      if (wb_valid || busy) beats++;
    end
    n_cmp++;
    if (beats != 0) begin
      n_err++;
      $display("FAIL async_reset_after activity_cycles got=%0d want=0", beats);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_flush_done();
    test_start_while_busy();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exu_div.md
Name: exu_div

Overview:
- Iterative radix-2 restoring divider in the EXU, directly downstream of the decode/issue stage.
- Consumes an issued DIV/DIVU/REM/REMU packet: operands, rd address and tag.
- Drives `busy` back to issue; issue stalls on it while the last issued instruction was a divide.
- Returns one write-back beat per accepted operation.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, issue strobe (div & legal & ~nop of the issued packet).
- rs1_data, input, XLEN, dividend.
- rs2_data, input, XLEN, divisor.
- rem, input, 1, 1 = return remainder, 0 = return quotient.
- unsign, input, 1, 1 = unsigned op (DIVU/REMU).
- rd_addr, input, 5, destination register.
- instr_tag, input, 32, instruction tag carried to WB.
- flush, input, 1, pipeline flush; abort in-flight op.
- busy, output, 1, registered; high while an op is in flight.
- wb_valid, output, 1, one-cycle result strobe.
- wb_data, output, XLEN, result.
- wb_rd_addr, output, 5, destination of result.
- wb_instr_tag, output, 32, tag of result.

Behaviour:
- Reset: state IDLE; busy=0, wb_valid=0, wb_data=0, wb_rd_addr=0, wb_instr_tag=0; all internal regs 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Sample start on clock edge (cycle 0); latch rem, unsign, rd_addr, instr_tag.
  - Divisor==0 or signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, unsign=0): go straight to DONE with the special result.
  - Otherwise latch |rs1| and |rs2| (raw values when unsign=1), record quotient and remainder sign, clear partial remainder, set counter=XLEN, go to CALC.
- CALC, one quotient bit per cycle, MSB first:
  - Shift {rem, dividend} left 1.
  - Trial subtract the divisor from the XLEN+1-bit remainder.
  - If the result is non-negative, keep it and set the quotient bit to 1.
  - Decrement the counter; leave for DONE when the counter reaches 0 after the XLEN-th iteration.
- DONE:
  - Sign fix-up: quotient is negated iff signed and operand signs differ; remainder takes the dividend's sign.
  - wb_valid=1 for exactly this cycle, with wb_data, wb_rd_addr, wb_instr_tag valid.
  - Next state IDLE.
- Latency:
  - Normal op: start at cycle 0, wb_valid at cycle XLEN+1 (33).
  - Special case: wb_valid at cycle 1.
- busy:
  - busy = (state != IDLE), registered.
  - High from cycle 1 through the DONE cycle inclusive; low the cycle after.
- Special results (RISC-V M):
  - Divide by zero: quotient 0xFFFFFFFF; remainder = rs1.
  - Signed overflow: quotient 0x80000000; remainder 0.
- start while busy=1: ignored; no latch, no state change (issue must not do this; the bench checks it is harmless).
- Flush:
  - Any state goes to IDLE next edge; wb_valid forced 0 that cycle (a DONE coinciding with flush produces no beat).
  - start in the same cycle as flush while IDLE is dropped.
- Write-back outputs hold their last values when wb_valid=0; consumers qualify on wb_valid.
- rd_addr=0 is not special-cased; the register file discards writes to x0.
- Async reset mid-operation: immediate return to reset values; no beat.

Test Plan:
- Basic DIVU: start with rs1=100, rs2=7, unsign=1, rem=0 -> busy high cycles 1..33; wb_valid at cycle 33 with wb_data=14 and the correct rd_addr/tag; busy=0 at cycle 34.
- Signed REM: rs1=-100 (0xFFFFFF9C), rs2=7, rem=1 -> wb_data=0xFFFFFFFE (-2). Same operands with rem=0 -> 0xFFFFFFF2 (-14).
- Divide by zero: rs1=5, rs2=0 -> DIVU gives 0xFFFFFFFF at cycle 1, busy high only cycle 1; REMU gives 5.
- Signed overflow: rs1=0x80000000, rs2=0xFFFFFFFF, DIV -> 0x80000000 at cycle 1; REM -> 0.
- Flush at cycle 10 of a DIVU -> no wb_valid ever; busy=0 at cycle 11; a new start at cycle 11 (20/3) completes with 6 at cycle 44.
- Robustness:
  - Second start while busy -> first result unchanged, no extra beat.
  - rst_n low at cycle 15 -> all outputs 0 immediately; no beat after release.
